// File: rtl/mer_pkg.sv
// Shared definitions for the MER ratio/log stage: default widths, FSM encoding
// and the saturated log value reported for a zero quotient.
package mer_pkg;
   localparam int NUM_W_DEF     = 18;
   localparam int DEN_W_DEF     = 56;
   localparam int ACC_SHIFT_DEF = 20;
   localparam int FRAC_DEF      = 8;
   localparam int LOG_W         = 9;

   localparam logic signed [LOG_W-1:0] LOG_MIN = {1'b1, {(LOG_W-1){1'b0}}};

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DIV  = 2'd1,
      ST_LOG  = 2'd2
   } state_t;
endpackage

// File: rtl/mer_calc_div.sv
// Bit-serial restoring divider: one quotient bit per clock, MSB first.
// A zero divisor naturally yields an all-ones quotient.
module restoring_div_serial #(
   parameter int DVD_W = 26,
   parameter int DVS_W = 36
) (
   input  logic             sys_clk,
   input  logic             reset,
   input  logic             start,
   input  logic [DVD_W-1:0] dividend,
   input  logic [DVS_W-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [DVD_W-1:0] quotient
);
   localparam int CNT_W = $clog2(DVD_W + 1);

   logic [CNT_W-1:0] cnt;
   logic [DVS_W-1:0] rem;
   logic [DVS_W-1:0] dvs;
   logic [DVD_W-1:0] q_sr;
   logic [DVS_W:0]   trial;
   logic             ge;

   // Dividend bits shift out of the top of q_sr while quotient bits shift in.
   assign trial    = {rem, q_sr[DVD_W-1]};
   assign ge       = (trial >= {1'b0, dvs});
   assign done     = busy && (cnt == CNT_W'(1));
   assign quotient = q_sr;

   always_ff @(posedge sys_clk or posedge reset) begin
      if (reset) begin
         busy <= 1'b0;
         cnt  <= '0;
      end else if (start && !busy) begin
         busy <= 1'b1;
         cnt  <= CNT_W'(DVD_W);
      end else if (busy) begin
         cnt <= cnt - CNT_W'(1);
         if (cnt == CNT_W'(1)) busy <= 1'b0;
      end
   end

   always_ff @(posedge sys_clk) begin
      if (start && !busy) begin
         rem  <= '0;
         dvs  <= divisor;
         q_sr <= dividend;
      end else if (busy) begin
         rem  <= ge ? DVS_W'(trial - {1'b0, dvs}) : DVS_W'(trial);
         q_sr <= {q_sr[DVD_W-2:0], ge};
      end
   end
endmodule

// File: rtl/mer_calc.sv
// MER = P_sig / P_err with a coarse log2 estimate, captured on each
// end-of-measurement strobe and reported with a one-cycle valid pulse.
module mer_calc
   import mer_pkg::*;
#(
   parameter int NUM_W     = NUM_W_DEF,
   parameter int DEN_W     = DEN_W_DEF,
   parameter int ACC_SHIFT = ACC_SHIFT_DEF,
   parameter int FRAC      = FRAC_DEF,
   localparam int Q_W      = NUM_W + FRAC
) (
   input  logic                    sys_clk,
   input  logic                    reset,
   input  logic                    start,
   input  logic signed [NUM_W-1:0] sig_pwr,
   input  logic        [DEN_W-1:0] err_acc,
   output logic                    busy,
   output logic                    valid,
   output logic        [Q_W-1:0]   mer_quot,
   output logic signed [LOG_W-1:0] mer_log2,
   output logic                    div_zero,
   output logic                    overrun
);
   localparam int DVS_W = DEN_W - ACC_SHIFT;

   state_t           state;
   logic             accept;
   logic [NUM_W-1:0] num_clamp;
   logic [DVS_W-1:0] den_in;
   logic [Q_W-1:0]   dividend;
   logic [Q_W-1:0]   div_q;
   logic [Q_W-1:0]   quot_final;
   logic             div_busy;
   logic             div_done;
   logic             den_zero_r;

   // Integer part at the leading one, next three bits as the 1/8 fraction.
   function automatic logic signed [LOG_W-1:0] log2_est(input logic [Q_W-1:0] q);
      int         p;
      int         v;
      logic [2:0] m;
      p = 0;
      for (int i = 0; i < Q_W; i++) if (q[i]) p = i;
      m = 3'({q, 3'b000} >> p);
      v = ((p - FRAC) * 8) + int'(m);
      if (q == '0) return LOG_MIN;
      return v[LOG_W-1:0];
   endfunction

   assign accept     = start && (state == ST_IDLE);
   assign num_clamp  = (sig_pwr < 0) ? '0 : NUM_W'($unsigned(sig_pwr));
   assign den_in     = DVS_W'(err_acc >> ACC_SHIFT);
   assign dividend   = {num_clamp, {FRAC{1'b0}}};
   assign quot_final = den_zero_r ? '1 : div_q;

   restoring_div_serial #(
      .DVD_W(Q_W),
      .DVS_W(DVS_W)
   ) u_div (
      .sys_clk (sys_clk),
      .reset   (reset),
      .start   (accept),
      .dividend(dividend),
      .divisor (den_in),
      .busy    (div_busy),
      .done    (div_done),
      .quotient(div_q)
   );

   always_ff @(posedge sys_clk) begin
      if (accept) den_zero_r <= (den_in == '0);
   end

   always_ff @(posedge sys_clk or posedge reset) begin
      if (reset) begin
         state    <= ST_IDLE;
         busy     <= 1'b0;
         valid    <= 1'b0;
         overrun  <= 1'b0;
         div_zero <= 1'b0;
         mer_quot <= '0;
         mer_log2 <= '0;
      end else begin
         valid   <= 1'b0;
         overrun <= start && (state != ST_IDLE);
         case (state)
            ST_IDLE: begin
               if (start) begin
                  state <= ST_DIV;
                  busy  <= 1'b1;
               end
            end
            ST_DIV: begin
               if (div_done) state <= ST_LOG;
            end
            ST_LOG: begin
               mer_quot <= quot_final;
               mer_log2 <= log2_est(quot_final);
               div_zero <= den_zero_r;
               valid    <= 1'b1;
               busy     <= 1'b0;
               state    <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   logic unused_ok;
   assign unused_ok = div_busy;
endmodule

// File: tb/tb_mer_calc.sv
// Self-checking bench for mer_calc: vector table plus scoreboard queue, and
// hand-written sequences for overrun and mid-division reset.
module tb_mer_calc;
   logic               sys_clk;
   logic               reset;
   logic               start;
   logic signed [17:0] sig_pwr;
   logic        [55:0] err_acc;
   logic               busy;
   logic               valid;
   logic        [25:0] mer_quot;
   logic signed [8:0]  mer_log2;
   logic               div_zero;
   logic               overrun;

   typedef struct {
      logic signed [17:0] sig;
      logic        [55:0] err;
      logic        [25:0] q;
      logic signed [8:0]  lg;
      logic               dz;
   } vec_t;

   typedef struct {
      logic        [25:0] q;
      logic signed [8:0]  lg;
      logic               dz;
   } exp_t;

   vec_t vecs[8];
   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;
   int   vld_cnt  = 0;
   int   ovr_cnt  = 0;
   int   v0;
   int   o0;

   mer_calc u_dut (
      .sys_clk (sys_clk),
      .reset   (reset),
      .start   (start),
      .sig_pwr (sig_pwr),
      .err_acc (err_acc),
      .busy    (busy),
      .valid   (valid),
      .mer_quot(mer_quot),
      .mer_log2(mer_log2),
      .div_zero(div_zero),
      .overrun (overrun)
   );

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   always @(posedge sys_clk) begin
      if (valid)   vld_cnt <= vld_cnt + 1;
      if (overrun) ovr_cnt <= ovr_cnt + 1;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic push_exp(input vec_t v);
      exp_t x;
      x.q  = v.q;
      x.lg = v.lg;
      x.dz = v.dz;
      sb.push_back(x);
   endtask

   task automatic launch(input logic signed [17:0] s, input logic [55:0] e);
      sig_pwr = s;
      err_acc = e;
      start   = 1'b1;
      @(posedge sys_clk);
      #1;
      start   = 1'b0;
   endtask

   // n0 = edges already elapsed since the edge that sampled start.
   task automatic collect(input int n0);
      int   n;
      bit   busy_ok;
      exp_t x;
      n       = n0;
      busy_ok = 1'b1;
      while (!valid && n < 60) begin
         if (!busy) busy_ok = 1'b0;
         @(posedge sys_clk);
         #1;
         n++;
      end
      chk("valid_seen", 64'(valid), 64'(1));
      chk("latency", 64'(n), 64'(28));
      chk("busy_during_div", 64'(busy_ok), 64'(1));
      chk("busy_low_at_valid", 64'(busy), 64'(0));
      if (sb.size() == 0) begin
         checks++;
         failures++;
         $display("FAIL scoreboard_empty actual=valid required=no_valid");
      end else begin
         x = sb.pop_front();
         chk("mer_quot", 64'(mer_quot), 64'(x.q));
         chk("mer_log2", 64'(mer_log2), 64'(x.lg));
         chk("div_zero", 64'(div_zero), 64'(x.dz));
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog_timeout actual=running required=finished");
      $fatal(1);
   end

   initial begin
      vecs[0] = '{18'sh10000, 56'h1000_0000,         26'h0010000, 9'sd64,  1'b0};
      vecs[1] = '{18'sd3,     56'h10_0000,           26'h0000300, 9'sd12,  1'b0};
      vecs[2] = '{18'sd100,   56'h0F_FFFF,           26'h3FFFFFF, 9'sd143, 1'b1};
      vecs[3] = '{-18'sd5,    56'h10_0000,           26'h0000000, 9'h100,  1'b0};
      vecs[4] = '{18'sh1FFFF, 56'h10_0000,           26'h1FFFF00, 9'sd135, 1'b0};
      vecs[5] = '{18'sh10000, 56'h100_0000_0000,     26'h0000010, -9'sd32, 1'b0};
      vecs[6] = '{18'sh1FFFF, 56'h10_0000_0000,      26'h00001FF, 9'sd7,   1'b0};
      vecs[7] = '{18'sd1,     56'hFF_FFFF_FFFF_FFFF, 26'h0000000, 9'h100,  1'b0};

      reset   = 1'b1;
      start   = 1'b0;
      sig_pwr = '0;
      err_acc = '0;
      repeat (3) @(posedge sys_clk);
      #1;
      chk("rst_busy",     64'(busy),     64'(0));
      chk("rst_valid",    64'(valid),    64'(0));
      chk("rst_overrun",  64'(overrun),  64'(0));
      chk("rst_div_zero", 64'(div_zero), 64'(0));
      chk("rst_mer_quot", 64'(mer_quot), 64'(0));
      chk("rst_mer_log2", 64'(mer_log2), 64'(0));
      reset = 1'b0;
      @(posedge sys_clk);
      #1;

      // Back-to-back: each new start lands in the previous valid cycle.
      for (int i = 0; i < 8; i++) begin
         push_exp(vecs[i]);
         launch(vecs[i].sig, vecs[i].err);
         collect(1);
      end
      chk("no_overrun_in_table", 64'(ovr_cnt), 64'(0));

      // Start while busy: second operands must be ignored.
      repeat (3) @(posedge sys_clk);
      #1;
      v0 = vld_cnt;
      o0 = ovr_cnt;
      push_exp(vecs[0]);
      launch(vecs[0].sig, vecs[0].err);
      repeat (9) @(posedge sys_clk);
      #1;
      launch(vecs[1].sig, vecs[1].err);
      collect(11);
      repeat (5) @(posedge sys_clk);
      #1;
      chk("overrun_pulses", 64'(ovr_cnt - o0), 64'(1));
      chk("valid_pulses",   64'(vld_cnt - v0), 64'(1));

      // Reset five cycles into a division.
      launch(vecs[0].sig, vecs[0].err);
      repeat (4) @(posedge sys_clk);
      #1;
      reset = 1'b1;
      #1;
      chk("abort_busy",     64'(busy),     64'(0));
      chk("abort_valid",    64'(valid),    64'(0));
      chk("abort_mer_quot", 64'(mer_quot), 64'(0));
      chk("abort_mer_log2", 64'(mer_log2), 64'(0));
      chk("abort_div_zero", 64'(div_zero), 64'(0));
      @(posedge sys_clk);
      #1;
      reset = 1'b0;
      v0 = vld_cnt;
      repeat (35) @(posedge sys_clk);
      #1;
      chk("no_valid_after_abort", 64'(vld_cnt - v0), 64'(0));
      chk("idle_after_abort",     64'(busy),         64'(0));
      push_exp(vecs[0]);
      launch(vecs[0].sig, vecs[0].err);
      collect(1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
